// File: rtl/floor_pkg.sv
// Shared floor geometry, coordinate type and collision FSM states used by the
// floor controller and floor_collision.
package floor_pkg;

  localparam int unsigned NUM_FLOORS = 5;
  localparam int unsigned FLOOR_W    = 90;
  localparam int unsigned FLOOR_H    = 20;
  localparam int unsigned IDX_W      = 3;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

endpackage

// File: rtl/floor_hit_check.sv
// Combinational test of one floor against the player: horizontal overlap and
// player bottom within [floor top, floor top + LAND_TOL]. 11-bit, no wrap.
module floor_hit_check
  import floor_pkg::*;
#(
  parameter int unsigned PLAYER_W = 16,
  parameter int unsigned PLAYER_H = 24,
  parameter int unsigned LAND_TOL = 4
) (
  input  coord_t i_floor_x,
  input  coord_t i_floor_y,
  input  coord_t i_player_x,
  input  coord_t i_player_y,
  output logic   o_hit
);

  logic [10:0] w_player_r;
  logic [10:0] w_player_b;
  logic [10:0] w_floor_r;
  logic [10:0] w_floor_tol;
  logic        w_overlap;
  logic        w_vertical;

  assign w_player_r  = {1'b0, i_player_x} + 11'(PLAYER_W);
  assign w_player_b  = {1'b0, i_player_y} + 11'(PLAYER_H);
  assign w_floor_r   = {1'b0, i_floor_x} + 11'(FLOOR_W);
  assign w_floor_tol = {1'b0, i_floor_y} + 11'(LAND_TOL);

  assign w_overlap  = (w_player_r > {1'b0, i_floor_x}) && ({1'b0, i_player_x} < w_floor_r);
  assign w_vertical = ({1'b0, i_floor_y} <= w_player_b) && (w_player_b <= w_floor_tol);
  assign o_hit      = w_overlap && w_vertical;

endmodule

// File: rtl/floor_collision.sv
// Per-frame floor landing detector: snapshots floors and player on a frame
// edge, scans one floor per cycle, then commits on_floor/snap/score/game-over.
module floor_collision
  import floor_pkg::*;
#(
  parameter int unsigned PLAYER_W  = 16,
  parameter int unsigned PLAYER_H  = 24,
  parameter int unsigned LAND_TOL  = 4,
  parameter int unsigned TOP_Y     = 10,
  parameter int unsigned BOTTOM_Y  = 479,
  parameter int unsigned SCORE_MAX = 999
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             i_frame_clk,
  input  coord_t           i_floor_x [NUM_FLOORS],
  input  coord_t           i_floor_y [NUM_FLOORS],
  input  coord_t           i_player_x,
  input  coord_t           i_player_y,
  output logic             o_on_floor,
  output logic [IDX_W-1:0] o_floor_idx,
  output coord_t           o_snap_y,
  output logic             o_result_valid,
  output logic [9:0]       o_score,
  output logic             o_game_over,
  output logic             o_busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_frame_clk_d;
  logic             w_edge;

  coord_t           r_fx [NUM_FLOORS];
  coord_t           r_fy [NUM_FLOORS];
  coord_t           r_px;
  coord_t           r_py;
  logic [IDX_W-1:0] r_idx;
  logic             r_hit_any;
  logic [IDX_W-1:0] r_hit_idx;
  logic             r_prev_on;
  logic [IDX_W-1:0] r_prev_idx;

  logic             r_on_floor;
  logic [IDX_W-1:0] r_floor_idx;
  coord_t           r_snap_y;
  logic             r_result_valid;
  logic [9:0]       r_score;
  logic             r_game_over;

  logic             w_hit;
  logic             w_last;
  logic             w_new_land;
  logic [10:0]      w_snap_full;
  logic [10:0]      w_pb;
  logic             w_dead;

  assign w_edge = i_frame_clk & ~r_frame_clk_d;
  assign w_last = (r_idx == IDX_W'(NUM_FLOORS - 1));

  floor_hit_check #(
    .PLAYER_W (PLAYER_W),
    .PLAYER_H (PLAYER_H),
    .LAND_TOL (LAND_TOL)
  ) u_hit (
    .i_floor_x  (r_fx[r_idx]),
    .i_floor_y  (r_fy[r_idx]),
    .i_player_x (r_px),
    .i_player_y (r_py),
    .o_hit      (w_hit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_edge) w_state_next = SCAN;
      SCAN:    if (w_last) w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_snap_full = {1'b0, r_fy[r_hit_idx]} - 11'(PLAYER_H);
  assign w_pb        = {1'b0, r_py} + 11'(PLAYER_H);
  assign w_dead      = (r_py <= 10'(TOP_Y)) || (w_pb >= 11'(BOTTOM_Y));
  // A landing counts when arriving from the air or switching to another floor.
  assign w_new_land  = r_hit_any && (!r_prev_on || (r_hit_idx != r_prev_idx));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_clk_d  <= 1'b0;
      r_fx           <= '{default: '0};
      r_fy           <= '{default: '0};
      r_px           <= '0;
      r_py           <= '0;
      r_idx          <= '0;
      r_hit_any      <= 1'b0;
      r_hit_idx      <= '0;
      r_prev_on      <= 1'b0;
      r_prev_idx     <= '0;
      r_on_floor     <= 1'b0;
      r_floor_idx    <= '0;
      r_snap_y       <= '0;
      r_result_valid <= 1'b0;
      r_score        <= '0;
      r_game_over    <= 1'b0;
    end else begin
      r_frame_clk_d  <= i_frame_clk;
      r_result_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_fx      <= i_floor_x;
            r_fy      <= i_floor_y;
            r_px      <= i_player_x;
            r_py      <= i_player_y;
            r_idx     <= '0;
            r_hit_any <= 1'b0;
            r_hit_idx <= '0;
          end
        end
        SCAN: begin
          // First hit locks the accumulator, so the lowest index wins.
          if (w_hit && !r_hit_any) begin
            r_hit_any <= 1'b1;
            r_hit_idx <= r_idx;
          end
          r_idx <= r_idx + 1'b1;
        end
        COMMIT: begin
          r_result_valid <= 1'b1;
          r_on_floor     <= r_hit_any;
          if (r_hit_any) begin
            r_floor_idx <= r_hit_idx;
            r_snap_y    <= w_snap_full[9:0];
          end
          if (!r_game_over && w_new_land && (r_score < 10'(SCORE_MAX))) begin
            r_score <= r_score + 1'b1;
          end
          r_prev_on  <= r_hit_any;
          r_prev_idx <= r_hit_idx;
          if (w_dead) r_game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_on_floor     = r_on_floor;
  assign o_floor_idx    = r_floor_idx;
  assign o_snap_y       = r_snap_y;
  assign o_result_valid = r_result_valid;
  assign o_score        = r_score;
  assign o_game_over    = r_game_over;
  assign o_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_floor_collision.sv
// Scoreboard bench for floor_collision: directed frames push expected results,
// a negedge monitor pops and compares whenever result_valid is seen.
module tb_floor_collision;
  import floor_pkg::*;

  typedef struct {
    logic       on;
    logic [2:0] idx;
    logic [9:0] snap;
    logic [9:0] score;
    logic       go;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  coord_t     fx [NUM_FLOORS];
  coord_t     fy [NUM_FLOORS];
  coord_t     px;
  coord_t     py;
  logic       on_floor;
  logic [2:0] floor_idx;
  coord_t     snap_y;
  logic       result_valid;
  logic [9:0] score;
  logic       game_over;
  logic       busy;

  exp_t sb [$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rv_count;

  always #10 Clk = ~Clk;

  floor_collision dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .i_frame_clk    (frame_clk),
    .i_floor_x      (fx),
    .i_floor_y      (fy),
    .i_player_x     (px),
    .i_player_y     (py),
    .o_on_floor     (on_floor),
    .o_floor_idx    (floor_idx),
    .o_snap_y       (snap_y),
    .o_result_valid (result_valid),
    .o_score        (score),
    .o_game_over    (game_over),
    .o_busy         (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge Clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        m_e = sb.pop_front();
        chk("on_floor", int'(on_floor), int'(m_e.on));
        chk("floor_idx", int'(floor_idx), int'(m_e.idx));
        chk("snap_y", int'(snap_y), int'(m_e.snap));
        chk("score", int'(score), int'(m_e.score));
        chk("game_over", int'(game_over), int'(m_e.go));
      end
    end
  end

  function automatic exp_t mk(input logic on, input int idx, input int snap, input int sc,
                              input logic go);
    exp_t e;
    e.on    = on;
    e.idx   = 3'(idx);
    e.snap  = 10'(snap);
    e.score = 10'(sc);
    e.go    = go;
    return e;
  endfunction

  // Issue one frame edge; check latency and busy width, optionally glitching
  // frame_clk mid-scan to present an edge that must be ignored.
  task automatic run_frame(input exp_t e, input bit glitch);
    int  busy_cnt;
    bit  seen;
    sb.push_back(e);
    @(negedge Clk) frame_clk = 1'b1;
    @(posedge Clk);
    #1;
    busy_cnt = int'(busy);
    seen     = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge Clk);
      #1;
      if (busy) busy_cnt++;
      if (result_valid) begin
        seen = 1'b1;
        chk("latency", k, 6);
      end
      if (glitch && k == 1) frame_clk = 1'b0;
      if (glitch && k == 2) frame_clk = 1'b1;
    end
    if (!seen) chk("result_timeout", 0, 1);
    chk("busy_cycles", busy_cnt, 6);
    @(negedge Clk) frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic set_default_floors();
    fx[0] = 10'd60;  fx[1] = 10'd80;  fx[2] = 10'd50;  fx[3] = 10'd190; fx[4] = 10'd140;
    fy[0] = 10'd120; fy[1] = 10'd200; fy[2] = 10'd300; fy[3] = 10'd350; fy[4] = 10'd420;
  endtask

  initial begin
    Reset     = 1'b1;
    frame_clk = 1'b0;
    set_default_floors();
    px = 10'd100;
    py = 10'd176;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_on_floor", int'(on_floor), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_valid", int'(result_valid), 0);
    @(negedge Clk) Reset = 1'b0;
    repeat (2) @(posedge Clk);

    run_frame(mk(1, 1, 176, 1, 0), 1'b0);
    fy[1] = 10'd199;
    run_frame(mk(1, 1, 175, 1, 0), 1'b0);
    fy[1] = 10'd200;
    run_frame(mk(1, 1, 176, 1, 0), 1'b0);
    px = 10'd0;
    run_frame(mk(0, 1, 176, 1, 0), 1'b0);
    px = 10'd100;
    py = 10'd180;
    run_frame(mk(1, 1, 176, 2, 0), 1'b0);
    py = 10'd181;
    run_frame(mk(0, 1, 176, 2, 0), 1'b0);
    // Both floor 0 and floor 1 hit; floor 0 must win.
    py = 10'd176;
    fy[0] = 10'd200;
    fy[1] = 10'd198;
    run_frame(mk(1, 0, 176, 3, 0), 1'b0);
    fy[0] = 10'd120;
    run_frame(mk(1, 1, 174, 4, 0), 1'b0);
    py = 10'd10;
    run_frame(mk(0, 1, 174, 4, 1), 1'b0);
    py = 10'd176;
    fy[0] = 10'd200;
    run_frame(mk(1, 0, 176, 4, 1), 1'b0);
    fy[0] = 10'd120;
    run_frame(mk(1, 1, 174, 4, 1), 1'b0);

    // Reset sampled at the third scan cycle aborts the frame.
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("midscan_busy_before", int'(busy), 1);
    @(negedge Clk);
    Reset     = 1'b1;
    frame_clk = 1'b0;
    @(posedge Clk);
    #1;
    chk("midscan_busy", int'(busy), 0);
    chk("midscan_on_floor", int'(on_floor), 0);
    chk("midscan_idx", int'(floor_idx), 0);
    chk("midscan_snap", int'(snap_y), 0);
    chk("midscan_score", int'(score), 0);
    chk("midscan_game_over", int'(game_over), 0);
    @(negedge Clk) Reset = 1'b0;
    rv_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      if (result_valid) rv_count++;
    end
    chk("midscan_no_valid", rv_count, 0);

    set_default_floors();
    px = 10'd100;
    py = 10'd176;
    run_frame(mk(1, 1, 176, 1, 0), 1'b1);
    rv_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      if (result_valid) rv_count++;
    end
    chk("ignored_edge_no_valid", rv_count, 0);

    py = 10'd454;
    run_frame(mk(0, 1, 176, 1, 0), 1'b0);
    py = 10'd455;
    run_frame(mk(0, 1, 176, 1, 1), 1'b0);

    repeat (4) @(posedge Clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
